encode83_keypad: RTL and testbench
==================================

# encode83_keypad

Debounced 8-key priority encoder: the reverse path of the 3-to-8 switch/LED decoder. Samples eight active-low push-buttons, synchronizes and debounces them, and reports the index of the pressed key as a 3-bit code with a held valid flag and a one-cycle press strobe. It sits between the board keys and downstream logic (the 3-8 decoder for LED echo, display drivers, counters).

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a press or a release (10 ms at 50 MHz); legal range 2 to 2^24.
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of the debounce counter; derived, not overridden.

- Clk_In  input  1  system clock; all state on rising edge.
- Rst_n_In  input  1  asynchronous, active-low reset.
- Key_In  input  8  raw buttons, active-low (0 = pressed), asynchronous to Clk_In.
- Code_Out  output  3  index of the accepted key; holds after release until the next accepted press.
- Valid_Out  output  1  high from press acceptance until release acceptance.
- Press_Pulse_Out  output  1  single-cycle strobe on press acceptance.
- Err_Out  output  1  multi-key error flag (see Configuration).

## Operation
- Two-flop synchronizer on Key_In; internal active-high vector k = ~sync2. Synchronizer flops reset to 8'hFF.
- Priority: highest set bit of k wins (key 7 over key 0).
- FSM states: IDLE, DB_PRESS, PRESSED, DB_REL. Reset state IDLE, counter 0, snapshot 0.
- IDLE: k != 0 -> capture snapshot = k, counter = 0, go DB_PRESS.
- DB_PRESS: k == 0 -> IDLE. k != snapshot -> snapshot = k, counter = 0, stay. k == snapshot and counter == DEBOUNCE_CYCLES-1 -> accept: Code_Out = priority(snapshot), Valid_Out = 1, Press_Pulse_Out = 1 for one cycle, go PRESSED. Otherwise counter++.
- PRESSED: k == 0 -> counter = 0, go DB_REL. Any other change in k (extra keys, key swap) ignored; Code_Out unchanged.
- DB_REL: k != 0 -> PRESSED (no new strobe, no code change). k == 0 and counter == DEBOUNCE_CYCLES-1 -> Valid_Out = 0, go IDLE. Otherwise counter++.
- A new press is reported only after a full accepted release; holding one key never produces a second strobe.
- Counter saturates never: it is always cleared on state entry, so no wrap-around occurs.

## Timing
- Reset values: Code_Out = 3'd0, Valid_Out = 0, Press_Pulse_Out = 0, Err_Out = 0; asserted Rst_n_In forces these immediately, mid-debounce or mid-press, and FSM to IDLE.
- Press latency: if Key_In is first sampled low at edge N and stays stable, Press_Pulse_Out, Valid_Out and Code_Out update at edge N+2+DEBOUNCE_CYCLES+1 (2 sync, 1 capture, DEBOUNCE_CYCLES count); Press_Pulse_Out falls at the next edge.
- Release latency: Key_In first sampled all-high at edge M -> Valid_Out falls at edge M+3+DEBOUNCE_CYCLES.
- Any bounce inside a debounce window restarts the full window from the bounce's sync output.
- Reset release is treated as all keys idle; a key held through reset is debounced as a fresh press.

## Configuration
- ENC83_MULTI_ERR_EN defined: at press acceptance, if snapshot has more than one bit set, no strobe, Valid_Out stays 0, Code_Out holds, Err_Out = 1; FSM still enters PRESSED and waits for release; Err_Out clears at the next accepted single-key press or reset.
- ENC83_MULTI_ERR_EN undefined: Err_Out tied to 0; multiple keys resolved by priority (highest index).

## Test plan
(All with DEBOUNCE_CYCLES = 8.)
- Reset then Key_In = 8'hFB held 30 cycles -> Press_Pulse_Out one cycle at edge N+11, Code_Out = 3'd2, Valid_Out = 1.
- Key_In = 8'hEF with 3 bounces (toggle to 8'hFF for 1 cycle) every 5 cycles -> no strobe until 8 stable cycles after last bounce; exactly one strobe, Code_Out = 3'd4.
- Hold 8'hFE, release with bounce back to 8'hFE at 4 cycles into DB_REL, then clean release -> single strobe total, Valid_Out falls 11 cycles after final release, Code_Out stays 3'd0.
- Key_In = 8'h7E (keys 7 and 0) -> macro off: Code_Out = 3'd7, strobe; macro on: Err_Out = 1, no strobe, Valid_Out = 0; then single key 8'hFD -> Err_Out = 0, Code_Out = 3'd1.
- Rst_n_In asserted at counter = 5 in DB_PRESS and during PRESSED -> outputs zero asynchronously; after release with key held, strobe at 11 cycles after first post-reset sample.
- Press key 3, then add key 6 while PRESSED -> Code_Out stays 3'd3, no extra strobe.

Source files
------------

// File: rtl/encode83_keypad.sv
// Debounced 8-key priority encoder for active-low push-buttons: reports the
// index of the accepted key, a held valid flag and a one-cycle press strobe.
// Optional multi-key error reporting is enabled by defining ENC83_MULTI_ERR_EN.
module encode83_keypad #(
    parameter int  DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       Clk_In,
    input  logic       Rst_n_In,
    input  logic [7:0] Key_In,
    output logic [2:0] Code_Out,
    output logic       Valid_Out,
    output logic       Press_Pulse_Out,
    output logic       Err_Out
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DB_PRESS = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] DB_REL   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sync1, sync2;
    logic [7:0]       k;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       snap;
    logic [2:0]       code_r;
    logic             valid_r;
    logic             pulse_r;

    function automatic logic [2:0] prio(input logic [7:0] v);
        prio = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) prio = 3'(i);
    endfunction

    // Synchronizer idles at all-ones so reset release looks like no key pressed.
    // NOTE: every clocked block uses <= so all flops sample pre-edge values.
    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            sync1 <= 8'hFF;
            sync2 <= 8'hFF;
        end else begin
            sync1 <= Key_In;
            sync2 <= sync1;
        end
    end

    assign k = ~sync2;

`ifdef ENC83_MULTI_ERR_EN
    logic err_r;
    logic multi;

    assign multi = (snap & (snap - 8'd1)) != 8'd0;
`endif

    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            state   <= IDLE;
            cnt     <= '0;
            snap    <= 8'h00;
            code_r  <= 3'd0;
            valid_r <= 1'b0;
            pulse_r <= 1'b0;
`ifdef ENC83_MULTI_ERR_EN
            err_r   <= 1'b0;
`endif
        end else begin
            pulse_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (k != 8'h00) begin
                        snap  <= k;
                        cnt   <= '0;
                        state <= DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (k == 8'h00) begin
                        state <= IDLE;
                    end else if (k != snap) begin
                        snap <= k;
                        cnt  <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= PRESSED;
`ifdef ENC83_MULTI_ERR_EN
                        if (multi) begin
                            err_r <= 1'b1;
                        end else begin
                            code_r  <= prio(snap);
                            valid_r <= 1'b1;
                            pulse_r <= 1'b1;
                            err_r   <= 1'b0;
                        end
`else
                        code_r  <= prio(snap);
                        valid_r <= 1'b1;
                        pulse_r <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    // Extra keys or swaps while held are ignored; only a full release counts.
                    if (k == 8'h00) begin
                        cnt   <= '0;
                        state <= DB_REL;
                    end
                end
                DB_REL: begin
                    if (k != 8'h00) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_MAX) begin
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered output stage: outputs land one edge after the FSM decision,
    // giving press latency 2+1+DEBOUNCE_CYCLES and release latency 3+DEBOUNCE_CYCLES.
    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            Code_Out        <= 3'd0;
            Valid_Out       <= 1'b0;
            Press_Pulse_Out <= 1'b0;
        end else begin
            Code_Out        <= code_r;
            Valid_Out       <= valid_r;
            Press_Pulse_Out <= pulse_r;
        end
    end

`ifdef ENC83_MULTI_ERR_EN
    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) Err_Out <= 1'b0;
        else           Err_Out <= err_r;
    end
`else
    assign Err_Out = 1'b0;
`endif

endmodule

// File: tb/tb_encode83_keypad.sv
// Directed testbench for encode83_keypad with DEBOUNCE_CYCLES = 8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_encode83_keypad;

    logic       Clk_In = 1'b0;
    logic       Rst_n_In = 1'b0;
    logic [7:0] Key_In = 8'hFF;
    logic [2:0] Code_Out;
    logic       Valid_Out;
    logic       Press_Pulse_Out;
    logic       Err_Out;

    int nvec = 0;
    int nerr = 0;

`ifdef ENC83_MULTI_ERR_EN
    localparam bit MULTI_ERR = 1'b1;
`else
    localparam bit MULTI_ERR = 1'b0;
`endif

    encode83_keypad #(.DEBOUNCE_CYCLES(8)) dut (
        .Clk_In         (Clk_In),
        .Rst_n_In       (Rst_n_In),
        .Key_In         (Key_In),
        .Code_Out       (Code_Out),
        .Valid_Out      (Valid_Out),
        .Press_Pulse_Out(Press_Pulse_Out),
        .Err_Out        (Err_Out)
    );

    always #5 Clk_In = ~Clk_In;

    task automatic test_reset();
        Rst_n_In = 1'b0;
        Key_In   = 8'hFF;
        repeat (3) @(negedge Clk_In);
        nvec++;
        if (Code_Out !== 3'd0 || Valid_Out !== 1'b0 || Press_Pulse_Out !== 1'b0 || Err_Out !== 1'b0) begin
            nerr++;
            $display("FAIL reset: got code=%0d valid=%b pulse=%b err=%b want all zero",
                     Code_Out, Valid_Out, Press_Pulse_Out, Err_Out);
        end
        Rst_n_In = 1'b1;
        @(negedge Clk_In);
    endtask

    task automatic test_press();
        Key_In = 8'hFB;
        for (int j = 1; j <= 30; j++) begin
            logic ep, ev;
            logic [2:0] ec;
            @(negedge Clk_In);
            ep = (j == 12);
            ev = (j >= 12);
            ec = (j >= 12) ? 3'd2 : 3'd0;
            nvec++;
            if (Press_Pulse_Out !== ep || Valid_Out !== ev || Code_Out !== ec || Err_Out !== 1'b0) begin
                nerr++;
                $display("FAIL press j=%0d: got pulse=%b valid=%b code=%0d err=%b want pulse=%b valid=%b code=%0d err=0",
                         j, Press_Pulse_Out, Valid_Out, Code_Out, Err_Out, ep, ev, ec);
            end
        end
        Key_In = 8'hFF;
        for (int j = 1; j <= 20; j++) begin
            logic ev;
            @(negedge Clk_In);
            ev = (j < 12);
            nvec++;
            if (Press_Pulse_Out !== 1'b0 || Valid_Out !== ev || Code_Out !== 3'd2) begin
                nerr++;
                $display("FAIL press_release j=%0d: got pulse=%b valid=%b code=%0d want pulse=0 valid=%b code=2",
                         j, Press_Pulse_Out, Valid_Out, Code_Out, ev);
            end
        end
    endtask

    task automatic test_bounce();
        for (int j = 1; j <= 34; j++) begin
            logic ep, ev;
            logic [2:0] ec;
            Key_In = (j == 5 || j == 10 || j == 15) ? 8'hFF : 8'hEF;
            @(negedge Clk_In);
            ep = (j == 27);
            ev = (j >= 27);
            ec = (j >= 27) ? 3'd4 : 3'd2;
            nvec++;
            if (Press_Pulse_Out !== ep || Valid_Out !== ev || Code_Out !== ec) begin
                nerr++;
                $display("FAIL bounce j=%0d: got pulse=%b valid=%b code=%0d want pulse=%b valid=%b code=%0d",
                         j, Press_Pulse_Out, Valid_Out, Code_Out, ep, ev, ec);
            end
        end
        Key_In = 8'hFF;
        for (int j = 1; j <= 14; j++) begin
            logic ev;
            @(negedge Clk_In);
            ev = (j < 12);
            nvec++;
            if (Valid_Out !== ev || Code_Out !== 3'd4) begin
                nerr++;
                $display("FAIL bounce_release j=%0d: got valid=%b code=%0d want valid=%b code=4",
                         j, Valid_Out, Code_Out, ev);
            end
        end
    endtask

    task automatic test_release_bounce();
        for (int j = 1; j <= 45; j++) begin
            logic ep, ev;
            logic [2:0] ec;
            Key_In = (j <= 20 || j == 27) ? 8'hFE : 8'hFF;
            @(negedge Clk_In);
            ep = (j == 12);
            ev = (j >= 12) && (j < 39);
            ec = (j >= 12) ? 3'd0 : 3'd4;
            nvec++;
            if (Press_Pulse_Out !== ep || Valid_Out !== ev || Code_Out !== ec) begin
                nerr++;
                $display("FAIL release_bounce j=%0d: got pulse=%b valid=%b code=%0d want pulse=%b valid=%b code=%0d",
                         j, Press_Pulse_Out, Valid_Out, Code_Out, ep, ev, ec);
            end
        end
    endtask

    task automatic test_multi();
        Key_In = 8'h7E;
        for (int j = 1; j <= 20; j++) begin
            logic ep, ev, ee;
            logic [2:0] ec;
            @(negedge Clk_In);
            ep = MULTI_ERR ? 1'b0 : (j == 12);
            ev = MULTI_ERR ? 1'b0 : (j >= 12);
            ec = (!MULTI_ERR && j >= 12) ? 3'd7 : 3'd0;
            ee = MULTI_ERR && (j >= 12);
            nvec++;
            if (Press_Pulse_Out !== ep || Valid_Out !== ev || Code_Out !== ec || Err_Out !== ee) begin
                nerr++;
                $display("FAIL multi j=%0d: got pulse=%b valid=%b code=%0d err=%b want pulse=%b valid=%b code=%0d err=%b",
                         j, Press_Pulse_Out, Valid_Out, Code_Out, Err_Out, ep, ev, ec, ee);
            end
        end
        Key_In = 8'hFF;
        for (int j = 1; j <= 15; j++) begin
            logic ev;
            @(negedge Clk_In);
            ev = !MULTI_ERR && (j < 12);
            nvec++;
            if (Valid_Out !== ev || Err_Out !== MULTI_ERR) begin
                nerr++;
                $display("FAIL multi_release j=%0d: got valid=%b err=%b want valid=%b err=%b",
                         j, Valid_Out, Err_Out, ev, MULTI_ERR);
            end
        end
        Key_In = 8'hFD;
        for (int j = 1; j <= 20; j++) begin
            logic ep, ev, ee;
            logic [2:0] ec;
            @(negedge Clk_In);
            ep = (j == 12);
            ev = (j >= 12);
            ec = (j >= 12) ? 3'd1 : (MULTI_ERR ? 3'd0 : 3'd7);
            ee = MULTI_ERR && (j < 12);
            nvec++;
            if (Press_Pulse_Out !== ep || Valid_Out !== ev || Code_Out !== ec || Err_Out !== ee) begin
                nerr++;
                $display("FAIL single_after_multi j=%0d: got pulse=%b valid=%b code=%0d err=%b want pulse=%b valid=%b code=%0d err=%b",
                         j, Press_Pulse_Out, Valid_Out, Code_Out, Err_Out, ep, ev, ec, ee);
            end
        end
        Key_In = 8'hFF;
        repeat (15) @(negedge Clk_In);
        nvec++;
        if (Valid_Out !== 1'b0 || Code_Out !== 3'd1) begin
            nerr++;
            $display("FAIL single_release: got valid=%b code=%0d want valid=0 code=1", Valid_Out, Code_Out);
        end
    endtask

    task automatic test_add_key();
        Key_In = 8'hF7;
        for (int j = 1; j <= 20; j++) begin
            logic ep, ev;
            logic [2:0] ec;
            @(negedge Clk_In);
            ep = (j == 12);
            ev = (j >= 12);
            ec = (j >= 12) ? 3'd3 : 3'd1;
            nvec++;
            if (Press_Pulse_Out !== ep || Valid_Out !== ev || Code_Out !== ec) begin
                nerr++;
                $display("FAIL add_key_press j=%0d: got pulse=%b valid=%b code=%0d want pulse=%b valid=%b code=%0d",
                         j, Press_Pulse_Out, Valid_Out, Code_Out, ep, ev, ec);
            end
        end
        Key_In = 8'hB7;
        for (int j = 1; j <= 20; j++) begin
            @(negedge Clk_In);
            nvec++;
            if (Press_Pulse_Out !== 1'b0 || Valid_Out !== 1'b1 || Code_Out !== 3'd3) begin
                nerr++;
                $display("FAIL add_key_hold j=%0d: got pulse=%b valid=%b code=%0d want pulse=0 valid=1 code=3",
                         j, Press_Pulse_Out, Valid_Out, Code_Out);
            end
        end
        Key_In = 8'hFF;
        repeat (15) @(negedge Clk_In);
    endtask

    task automatic test_reset_mid();
        Key_In = 8'hF7;
        repeat (8) @(negedge Clk_In);
        for (int r = 0; r < 2; r++) begin
            Rst_n_In = 1'b0;
            #1;
            nvec++;
            if (Code_Out !== 3'd0 || Valid_Out !== 1'b0 || Press_Pulse_Out !== 1'b0 || Err_Out !== 1'b0) begin
                nerr++;
                $display("FAIL async_reset r=%0d: got code=%0d valid=%b pulse=%b err=%b want all zero",
                         r, Code_Out, Valid_Out, Press_Pulse_Out, Err_Out);
            end
            repeat (2) @(negedge Clk_In);
            Rst_n_In = 1'b1;
            for (int j = 1; j <= 20; j++) begin
                logic ep, ev;
                logic [2:0] ec;
                @(negedge Clk_In);
                ep = (j == 12);
                ev = (j >= 12);
                ec = (j >= 12) ? 3'd3 : 3'd0;
                nvec++;
                if (Press_Pulse_Out !== ep || Valid_Out !== ev || Code_Out !== ec) begin
                    nerr++;
                    $display("FAIL post_reset r=%0d j=%0d: got pulse=%b valid=%b code=%0d want pulse=%b valid=%b code=%0d",
                             r, j, Press_Pulse_Out, Valid_Out, Code_Out, ep, ev, ec);
                end
            end
        end
        Key_In = 8'hFF;
        repeat (15) @(negedge Clk_In);
        nvec++;
        if (Valid_Out !== 1'b0 || Code_Out !== 3'd3) begin
            nerr++;
            $display("FAIL final_release: got valid=%b code=%0d want valid=0 code=3", Valid_Out, Code_Out);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_release_bounce();
        test_multi();
        test_add_key();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
